// File: rtl/demux1to4_stream.sv
// Registered 1-to-4 stream router. One valid/ready input fans out to four
// valid/ready outputs selected by a one-hot SEL code. Each output owns a
// one-entry holding register. Illegal SEL codes are consumed, dropped and
// counted in a saturating counter with a sticky error flag.
module demux1to4_stream #(
  parameter int BITWIDTH = 32
) (
  input  logic                CLK,
  input  logic                RESETn,
  input  logic [BITWIDTH-1:0] DI,
  input  logic [3:0]          SEL,
  input  logic                DI_VALID,
  output logic                DI_READY,
  output logic [BITWIDTH-1:0] DO0,
  output logic [BITWIDTH-1:0] DO1,
  output logic [BITWIDTH-1:0] DO2,
  output logic [BITWIDTH-1:0] DO3,
  output logic [3:0]          DO_VALID,
  input  logic [3:0]          DO_READY,
  output logic                ERR,
  output logic [7:0]          DROP_CNT,
  input  logic                ERR_CLR
);

  logic                sel_legal;
  logic [3:0]          valid_q;
  logic [3:0]          drain;
  logic [3:0]          slot_free;
  logic [3:0]          load;
  logic                accept;
  logic                illegal_accept;
  logic [BITWIDTH-1:0] data_q [4];
  logic                err_q;
  logic                err_d;
  logic [7:0]          cnt_q;
  logic [7:0]          cnt_d;

  // Handshake: ready depends only on SEL and output-side state, never on DI_VALID.
  always_comb begin
    sel_legal      = (SEL != 4'b0000) && ((SEL & (SEL - 4'd1)) == 4'b0000);
    drain          = valid_q & DO_READY;
    slot_free      = ~valid_q | drain;
    DI_READY       = RESETn & (sel_legal ? |(SEL & slot_free) : 1'b1);
    accept         = DI_VALID & DI_READY;
    illegal_accept = accept & ~sel_legal;
    load           = (accept && sel_legal) ? SEL : 4'b0000;
  end

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_port
      logic                vld_d;
      logic                vld_q;
      logic [BITWIDTH-1:0] dat_d;
      logic [BITWIDTH-1:0] dat_q;

      // Next state of one holding slot: load wins over drain so a drain and
      // reload in the same cycle keeps the slot full with no bubble.
      always_comb begin
        vld_d = vld_q;
        dat_d = dat_q;
        if (load[gi]) begin
          vld_d = 1'b1;
          dat_d = DI;
        end else if (drain[gi]) begin
          vld_d = 1'b0;
        end
      end

      // Slot registers; reset discards any held word immediately.
      always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
          vld_q <= 1'b0;
          dat_q <= '0;
        end else begin
          vld_q <= vld_d;
          dat_q <= dat_d;
        end
      end

      assign valid_q[gi] = vld_q;
      assign data_q[gi]  = dat_q;
    end
  endgenerate

  // Error bookkeeping: an illegal accept takes priority over a clear request.
  always_comb begin
    err_d = err_q;
    cnt_d = cnt_q;
    if (illegal_accept) begin
      err_d = 1'b1;
      if (ERR_CLR)
        cnt_d = 8'd1;
      else if (cnt_q != 8'hFF)
        cnt_d = cnt_q + 8'd1;
    end else if (ERR_CLR) begin
      err_d = 1'b0;
      cnt_d = 8'd0;
    end
  end

  // Error flag and drop counter registers.
  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      err_q <= 1'b0;
      cnt_q <= 8'd0;
    end else begin
      err_q <= err_d;
      cnt_q <= cnt_d;
    end
  end

  assign DO0      = data_q[0];
  assign DO1      = data_q[1];
  assign DO2      = data_q[2];
  assign DO3      = data_q[3];
  assign DO_VALID = valid_q;
  assign ERR      = err_q;
  assign DROP_CNT = cnt_q;

endmodule

// File: tb/tb_demux1to4_stream.sv
// Directed bench for demux1to4_stream with a per-port scoreboard of expected
// words plus a reference model of the error flag and drop counter.
module tb_demux1to4_stream;

  logic        CLK = 1'b0;
  logic        RESETn;
  logic [31:0] DI;
  logic [3:0]  SEL;
  logic        DI_VALID;
  logic        DI_READY;
  logic [31:0] DO0, DO1, DO2, DO3;
  logic [3:0]  DO_VALID;
  logic [3:0]  DO_READY;
  logic        ERR;
  logic [7:0]  DROP_CNT;
  logic        ERR_CLR;

  logic [31:0] dout [4];
  assign dout[0] = DO0;
  assign dout[1] = DO1;
  assign dout[2] = DO2;
  assign dout[3] = DO3;

  demux1to4_stream #(.BITWIDTH(32)) dut (
    .CLK(CLK), .RESETn(RESETn), .DI(DI), .SEL(SEL), .DI_VALID(DI_VALID),
    .DI_READY(DI_READY), .DO0(DO0), .DO1(DO1), .DO2(DO2), .DO3(DO3),
    .DO_VALID(DO_VALID), .DO_READY(DO_READY), .ERR(ERR), .DROP_CNT(DROP_CNT),
    .ERR_CLR(ERR_CLR)
  );

  always #5 CLK = ~CLK;

  int errors = 0;
  int checks = 0;

  logic [31:0] sbq [4][$];
  logic        exp_err = 1'b0;
  int          exp_cnt = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic bit is_legal(input logic [3:0] s);
    int n = 0;
    for (int i = 0; i < 4; i++) if (s[i]) n++;
    return n == 1;
  endfunction

  function automatic int sel_idx(input logic [3:0] s);
    for (int i = 0; i < 4; i++) if (s[i]) return i;
    return 0;
  endfunction

  // One clock cycle: check the combinational ready, update the model, then
  // after the edge check every registered output against the model.
  task automatic step();
    bit   legal;
    int   idx;
    logic exp_rdy;
    logic [3:0] exp_vld;
    #3;
    legal   = is_legal(SEL);
    idx     = sel_idx(SEL);
    exp_rdy = legal ? ((sbq[idx].size() == 0) || DO_READY[idx]) : 1'b1;
    chk("di_ready", {63'd0, DI_READY}, {63'd0, exp_rdy});
    for (int i = 0; i < 4; i++)
      if (sbq[i].size() > 0 && DO_READY[i]) void'(sbq[i].pop_front());
    if (DI_VALID && exp_rdy && legal) begin
      sbq[idx].push_back(DI);
    end else if (DI_VALID && exp_rdy && !legal) begin
      exp_err = 1'b1;
      exp_cnt = ERR_CLR ? 1 : ((exp_cnt == 255) ? 255 : exp_cnt + 1);
    end else if (ERR_CLR) begin
      exp_err = 1'b0;
      exp_cnt = 0;
    end
    $display("t=%0t sel=%b di=%h valid=%b ready=%b do_ready=%b", $time, SEL, DI, DI_VALID, DI_READY, DO_READY);
    @(posedge CLK);
    #1;
    for (int i = 0; i < 4; i++) begin
      exp_vld[i] = (sbq[i].size() > 0);
      if (sbq[i].size() > 0) chk($sformatf("do%0d", i), {32'd0, dout[i]}, {32'd0, sbq[i][0]});
    end
    chk("do_valid", {60'd0, DO_VALID}, {60'd0, exp_vld});
    chk("err", {63'd0, ERR}, {63'd0, exp_err});
    chk("drop_cnt", {56'd0, DROP_CNT}, 64'(exp_cnt));
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, "_valid"}, {60'd0, DO_VALID}, 64'd0);
    chk({tag, "_do0"}, {32'd0, DO0}, 64'd0);
    chk({tag, "_do1"}, {32'd0, DO1}, 64'd0);
    chk({tag, "_do2"}, {32'd0, DO2}, 64'd0);
    chk({tag, "_do3"}, {32'd0, DO3}, 64'd0);
    chk({tag, "_err"}, {63'd0, ERR}, 64'd0);
    chk({tag, "_cnt"}, {56'd0, DROP_CNT}, 64'd0);
    chk({tag, "_ready"}, {63'd0, DI_READY}, 64'd0);
  endtask

  initial begin
    RESETn = 1'b0; DI = '0; SEL = 4'b0001; DI_VALID = 1'b0;
    DO_READY = 4'h0; ERR_CLR = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    check_reset_state("reset");
    RESETn = 1'b1;

    // Single word to port 2, then drained.
    DI = 32'hA5A5_0001; SEL = 4'b0100; DI_VALID = 1'b1; DO_READY = 4'hF;
    step();
    chk("t1_do2", {32'd0, DO2}, 64'hA5A5_0001);
    chk("t1_valid", {60'd0, DO_VALID}, 64'b0100);
    chk("t1_do0", {32'd0, DO0}, 64'd0);
    DI_VALID = 1'b0;
    step();

    // Port 1 stall then drain-and-reload in one cycle.
    DO_READY = 4'h0; SEL = 4'b0010; DI = 32'h1111_0001; DI_VALID = 1'b1;
    step();
    DI = 32'h1111_0002;
    step();
    step();
    DO_READY = 4'b0010;
    step();
    chk("t2_reload", {32'd0, DO1}, 64'h1111_0002);
    DI_VALID = 1'b0;
    step();

    // Back-to-back stream of 8 words into port 0.
    DO_READY = 4'b0001; SEL = 4'b0001; DI_VALID = 1'b1;
    for (int k = 0; k < 8; k++) begin
      DI = 32'hC0DE_0000 + 32'(k);
      step();
    end
    DI_VALID = 1'b0;
    step();

    // Park a word in port 3, then illegal codes and clear interactions.
    DO_READY = 4'h0; SEL = 4'b1000; DI = 32'h3333_3333; DI_VALID = 1'b1;
    step();
    SEL = 4'b0000; DI = 32'hDEAD_0000;
    step();
    SEL = 4'b0011;
    step();
    chk("t4_err", {63'd0, ERR}, 64'd1);
    chk("t4_cnt", {56'd0, DROP_CNT}, 64'd2);
    chk("t4_valid", {60'd0, DO_VALID}, 64'b1000);
    ERR_CLR = 1'b1; SEL = 4'b0101;
    step();
    chk("t4_setwins", {56'd0, DROP_CNT}, 64'd1);
    DI_VALID = 1'b0;
    step();
    chk("t4_clr", {56'd0, DROP_CNT}, 64'd0);
    ERR_CLR = 1'b0;

    // Saturation of the drop counter.
    SEL = 4'b1111; DI_VALID = 1'b1;
    for (int k = 0; k < 300; k++) step();
    chk("t5_sat", {56'd0, DROP_CNT}, 64'd255);
    chk("t5_err", {63'd0, ERR}, 64'd1);

    // Ports 0 and 3 full and stalled; reset asserted between edges.
    SEL = 4'b0001; DI = 32'h0000_AAAA;
    step();
    DI_VALID = 1'b0;
    chk("t6_full", {60'd0, DO_VALID}, 64'b1001);
    #2;
    RESETn = 1'b0;
    #1;
    check_reset_state("async_rst");
    for (int i = 0; i < 4; i++) sbq[i].delete();
    exp_err = 1'b0;
    exp_cnt = 0;
    @(posedge CLK);
    #1;
    RESETn = 1'b1;
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
